// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS + 1);
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between execute stage and divider
interface div_unit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             divIsActive;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  divIsActive, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output divIsActive, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract step on magnitudes
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);
    // One extra bit: the shifted remainder can exceed WIDTH bits for large unsigned divisors.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           take;

    assign shifted = {rem_i, dvd_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_i};
    assign take    = (shifted >= {1'b0, dsr_i});
    assign rem_o   = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_o   = {dvd_i[WIDTH-2:0], take};
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative signed/unsigned divider with PC stall output
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITERS = WIDTH
) (
    input logic       clk,
    input logic       rst_n,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(ITERS + 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             dz_q, dz_d, flag_q, flag_d, done_q, done_d;
    logic [WIDTH-1:0] step_rem, step_dvd;
    logic             a_neg, b_neg;

    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Divide by zero reuses FIX: the forced result rides in dvd/rem unnegated.
                    if (bus.divisor == '0) begin
                        dvd_d   = '1;
                        rem_d   = bus.dividend;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        dz_d    = 1'b1;
                        state_d = FIX;
                    end else begin
                        dvd_d   = a_neg ? -bus.dividend : bus.dividend;
                        dsr_d   = b_neg ? -bus.divisor : bus.divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        dz_d    = 1'b0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = q_neg_q ? -dvd_q : dvd_q;
                rmd_d   = r_neg_q ? -rem_q : rem_q;
                flag_d  = dz_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.divIsActive = (state_q != IDLE) | bus.start;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = flag_q;
endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the pipelined core's execute stage. It accepts one signed or unsigned division per request. It drives `divIsActive`, which the PC update logic consumes to hold the PC for the whole operation. Results (`quotient`/`remainder`, the LO/HI pair) are registered and held until the next completed division.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `ITERS`, `WIDTH`: iteration count, one quotient bit per cycle.

Ports:
- `clk` in 1: sole clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a division; sampled only in IDLE.
- `is_signed` in 1: 1 = two's-complement operands, 0 = unsigned; captured with `start`.
- `dividend` in WIDTH: captured with `start`.
- `divisor` in WIDTH: captured with `start`.
- `divIsActive` out 1: busy / stall request to PC update logic.
- `done` out 1: one-cycle pulse; results valid from this cycle.
- `quotient` out WIDTH: LO result, held.
- `remainder` out WIDTH: HI result, held.
- `div_by_zero` out 1: flag for the last completed operation, held.

## Operation
- Reset (async, any state): state goes to IDLE; `quotient`, `remainder`, `div_by_zero` and `done` go to 0; `divIsActive` goes to 0; any in-flight operation is discarded with no `done`.
- States: IDLE → ITER → FIX → IDLE.
- **IDLE, `start`=1, `divisor`≠0**: load |dividend| and |divisor| (magnitudes only if `is_signed`), clear the partial remainder, and set the counter to 0. Record `q_neg = is_signed & (sign(a) ^ sign(b))` and `r_neg = is_signed & sign(a)`. Next state is ITER.
- **IDLE, `start`=1, `divisor`=0**: no iteration. Next state is FIX with the forced result `quotient`=all-ones, `remainder`=dividend, `div_by_zero`=1.
- **ITER**: restoring step each cycle.
  - Shift {rem, dvd} left by 1.
  - If rem ≥ divisor magnitude: subtract, and the quotient bit is 1.
  - The counter increments each cycle. After ITERS cycles, go to FIX.
- **FIX**: negate the quotient if `q_neg`, negate the remainder if `r_neg`, write the output registers, then go to IDLE.
  - `done` is registered and is high for the first IDLE cycle only.
- Signed semantics:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case −2^31 / −1 gives `quotient`=32'h8000_0000, `remainder`=0, and `div_by_zero`=0. This is the natural result of the magnitude algorithm; no special case is needed.
- `start` while not in IDLE is ignored. The requester must hold the instruction in decode while `divIsActive`=1.
- `start` in the same cycle `done`=1 (state is IDLE) is accepted normally.
- Outputs change only at the FIX→IDLE edge. They are stable at all other times, including during a following operation.

## Timing
- `divIsActive` = (state≠IDLE) | (state==IDLE & `start`). The `start` term is combinational, so the PC holds in the request cycle itself. `divIsActive` is 0 in the `done` cycle.
- Normal operation, with request in cycle 0:
  - ITER runs in cycles 1..32.
  - FIX is cycle 33.
  - `done`=1 and results are valid in cycle 34.
  - `divIsActive` is high in cycles 0..33, i.e. 34 stall cycles.
- Divide by zero, with request in cycle 0: FIX in cycle 1, `done` in cycle 2, `divIsActive` high in cycles 0..1.
- No combinational path from operand inputs to any output. `start` → `divIsActive` is the only combinational path.

## Structure
- Package `div_pkg`:
  - `div_state_t` enum {IDLE, ITER, FIX}.
  - `DIV_WIDTH`=32.
  - `DIV_CNT_W`=$clog2(ITERS+1).
  - `DIV0_QUOTIENT`=all-ones.
- Sub-module `div_step`: combinational, one restoring shift-subtract step.
  - Inputs: rem, dvd, dsr.
  - Outputs: next rem, next dvd with the quotient bit in the LSB.
  - Instantiated once in `div_unit`; the bench reuses it for a unit check.

## Test plan
- Unsigned 100 / 7: `start` cycle 0 → `divIsActive` high for cycles 0..33; `done` in cycle 34 with quotient=14, remainder=2, div_by_zero=0.
- Signed −100 / 7, then 100 / −7 → q=−14 / r=−2, then q=−14 / r=2. Outputs hold between `done` pulses.
- Divide by zero, unsigned 0x1234 / 0 → `done` in cycle 2 with quotient=0xFFFF_FFFF, remainder=0x1234, div_by_zero=1. Signed 0x8000_0000 / −1 → q=0x8000_0000, r=0, flag=0.
- `start` pulsed at cycle 10 of a busy operation with different operands → ignored; the first operation's result is unchanged. Back-to-back `start` in the `done` cycle → second result in cycle 68.
- `rst_n` low in cycle 20 of an operation → all outputs 0 immediately, no `done`; a new `start` after release completes normally (0xFFFF_FFFF / 0x10 → q=0x0FFF_FFFF, r=0xF).
- Random compare against a reference model for 10k signed/unsigned pairs, including 0, ±1, 0x8000_0000 and 0x7FFF_FFFF.
